// File: rtl/inst_queue_ctrl_if.sv
// Fetch/decode-side bundle of the instruction queue: push pair, issue pops, head outputs, status.
// err_sticky is present only when INST_QUEUE_ERR_CHK_EN is defined.
interface inst_queue_ctrl_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              flush;
    logic              push_en0;
    logic              push_en1;
    logic [DATA_W-1:0] push_data0;
    logic [DATA_W-1:0] push_data1;
    logic              pop_master;
    logic              pop_slave;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic              out_valid0;
    logic              out_valid1;
    logic              fifo_empty;
    logic              fifo_almost_empty;
    logic              fifo_full;
    logic [PTR_W:0]    count;
`ifdef INST_QUEUE_ERR_CHK_EN
    logic              err_sticky;

    modport master (
        output flush, push_en0, push_en1, push_data0, push_data1, pop_master, pop_slave,
        input  out_data0, out_data1, out_valid0, out_valid1,
               fifo_empty, fifo_almost_empty, fifo_full, count, err_sticky
    );
    modport slave (
        input  flush, push_en0, push_en1, push_data0, push_data1, pop_master, pop_slave,
        output out_data0, out_data1, out_valid0, out_valid1,
               fifo_empty, fifo_almost_empty, fifo_full, count, err_sticky
    );
`else
    modport master (
        output flush, push_en0, push_en1, push_data0, push_data1, pop_master, pop_slave,
        input  out_data0, out_data1, out_valid0, out_valid1,
               fifo_empty, fifo_almost_empty, fifo_full, count
    );
    modport slave (
        input  flush, push_en0, push_en1, push_data0, push_data1, pop_master, pop_slave,
        output out_data0, out_data1, out_valid0, out_valid1,
               fifo_empty, fifo_almost_empty, fifo_full, count
    );
`endif
endinterface

// File: rtl/inst_queue_ctrl.sv
// Dual-push / dual-pop instruction queue feeding the master and slave decode slots.
// Optional build macro INST_QUEUE_ERR_CHK_EN adds a sticky illegal-request flag.
module inst_queue_ctrl #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    inst_queue_ctrl_if.slave q
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic              full;
    logic              master_pop;
    logic              slave_pop;
    logic [1:0]        push_cnt;
    logic [1:0]        pop_cnt;

    // Full means fewer than two free slots, so a pair push can never overflow.
    assign full = (cnt >= FULL_LVL);

    always_comb begin
        push_cnt = 2'd0;
        if (!full && q.push_en0) begin
            push_cnt = q.push_en1 ? 2'd2 : 2'd1;
        end
    end

    assign master_pop = q.pop_master && (cnt >= ONE);
    assign slave_pop  = q.pop_slave && master_pop && (cnt >= TWO);
    assign pop_cnt    = {1'b0, master_pop} + {1'b0, slave_pop};

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            cnt    <= cnt + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !q.flush) begin
            if (push_cnt != 2'd0) mem[wr_ptr] <= q.push_data0;
            if (push_cnt == 2'd2) mem[wr_ptr + PTR_W'(1)] <= q.push_data1;
        end
    end

    assign q.out_data0         = mem[rd_ptr];
    assign q.out_data1         = mem[rd_ptr + PTR_W'(1)];
    assign q.out_valid0        = (cnt >= ONE);
    assign q.out_valid1        = (cnt >= TWO);
    assign q.fifo_empty        = (cnt == '0);
    assign q.fifo_almost_empty = (cnt == ONE);
    assign q.fifo_full         = full;
    assign q.count             = cnt;

`ifdef INST_QUEUE_ERR_CHK_EN
    logic err_sticky_r;
    logic err_evt;

    assign err_evt = (q.push_en0 && full)
                   || (q.push_en1 && !q.push_en0)
                   || (q.pop_master && (cnt == '0))
                   || (q.pop_slave && ((cnt < TWO) || !q.pop_master));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
        end else if (!q.flush && err_evt) begin
            err_sticky_r <= 1'b1;
        end
    end

    assign q.err_sticky = err_sticky_r;
`endif
endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Scoreboard bench for inst_queue_ctrl: a queue-based reference model feeds expectations to a negedge monitor.
module tb_inst_queue_ctrl;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;

    typedef struct {
        int          cnt;
        bit          v0;
        bit          v1;
        bit          em;
        bit          ae;
        bit          fu;
        logic [63:0] d0;
        logic [63:0] d1;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [63:0] mq[$];
    exp_t        exp_q[$];
    bit          err_m = 1'b0;

    inst_queue_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) qif ();

    inst_queue_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: whenever an expectation is pending, compare what the DUT presents.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("count", 64'(qif.count), 64'(e.cnt));
                chk("out_valid0", 64'(qif.out_valid0), 64'(e.v0));
                chk("out_valid1", 64'(qif.out_valid1), 64'(e.v1));
                chk("fifo_empty", 64'(qif.fifo_empty), 64'(e.em));
                chk("fifo_almost_empty", 64'(qif.fifo_almost_empty), 64'(e.ae));
                chk("fifo_full", 64'(qif.fifo_full), 64'(e.fu));
                if (e.v0) chk("out_data0", qif.out_data0, e.d0);
                if (e.v1) chk("out_data1", qif.out_data1, e.d1);
`ifdef INST_QUEUE_ERR_CHK_EN
                chk("err_sticky", 64'(qif.err_sticky), 64'(e.err));
`endif
            end
        end
    end

    // One clock of stimulus; the model applies the same request to a plain queue.
    task automatic step(input bit r, input bit f, input bit pe0, input bit pe1,
                        input bit pm, input bit ps, input logic [63:0] d0, input logic [63:0] d1);
        int   c;
        int   npush;
        bit   mp;
        bit   sp;
        exp_t e;
        rst             = r;
        qif.flush       = f;
        qif.push_en0    = pe0;
        qif.push_en1    = pe1;
        qif.pop_master  = pm;
        qif.pop_slave   = ps;
        qif.push_data0  = d0;
        qif.push_data1  = d1;
        @(posedge clk);
        c = mq.size();
        if (r) begin
            mq.delete();
            err_m = 1'b0;
        end else if (f) begin
            mq.delete();
        end else begin
            mp    = pm && (c >= 1);
            sp    = ps && mp && (c >= 2);
            npush = (c >= DEPTH - 1 || !pe0) ? 0 : (pe1 ? 2 : 1);
            if ((pe0 && c >= DEPTH - 1) || (pe1 && !pe0) || (pm && c == 0) || (ps && (c < 2 || !pm)))
                err_m = 1'b1;
            if (mp) void'(mq.pop_front());
            if (sp) void'(mq.pop_front());
            if (npush >= 1) mq.push_back(d0);
            if (npush == 2) mq.push_back(d1);
        end
        c     = mq.size();
        e.cnt = c;
        e.v0  = (c >= 1);
        e.v1  = (c >= 2);
        e.em  = (c == 0);
        e.ae  = (c == 1);
        e.fu  = (c >= DEPTH - 1);
        e.d0  = (c >= 1) ? mq[0] : 64'h0;
        e.d1  = (c >= 2) ? mq[1] : 64'h0;
        e.err = err_m;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    endtask

    task automatic push1(input logic [63:0] d0);
        step(0, 0, 1, 0, 0, 0, d0, 64'h0);
    endtask

    task automatic push2(input logic [63:0] d0, input logic [63:0] d1);
        step(0, 0, 1, 1, 0, 0, d0, d1);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        qif.flush = 0; qif.push_en0 = 0; qif.push_en1 = 0;
        qif.pop_master = 0; qif.pop_slave = 0;
        qif.push_data0 = '0; qif.push_data1 = '0;
        @(negedge clk);
        do_reset();
        chk("reset empty", 64'(qif.fifo_empty), 64'd1);
        chk("reset count", 64'(qif.count), 64'd0);

        // Two pairs, then a dual pop.
        push2(64'hA0, 64'hA1);
        push2(64'hB0, 64'hB1);
        chk("pairs count", 64'(qif.count), 64'd4);
        chk("pairs head0", qif.out_data0, 64'hA0);
        chk("pairs head1", qif.out_data1, 64'hA1);
        step(0, 0, 0, 0, 1, 1, 64'h0, 64'h0);
        chk("dual pop count", 64'(qif.count), 64'd2);
        chk("dual pop head0", qif.out_data0, 64'hB0);

        // Single entry: a dual pop retires only one.
        do_reset();
        push1(64'hC0);
        chk("single almost_empty", 64'(qif.fifo_almost_empty), 64'd1);
        chk("single valid1", 64'(qif.out_valid1), 64'd0);
        step(0, 0, 0, 0, 1, 1, 64'h0, 64'h0);
        chk("single pop empty", 64'(qif.fifo_empty), 64'd1);

        // Full queue rejects a push even with a concurrent pop.
        push2(64'h10, 64'h11);
        push2(64'h12, 64'h13);
        push2(64'h14, 64'h15);
        push1(64'h16);
        chk("fill full", 64'(qif.fifo_full), 64'd1);
        step(0, 0, 1, 1, 1, 0, 64'h17, 64'h18);
        chk("full reject count", 64'(qif.count), 64'd6);
        push2(64'h19, 64'h1A);
        chk("refill count", 64'(qif.count), 64'd8);
        chk("refill head0", qif.out_data0, 64'h11);

        // Bring both pointers to DEPTH-1, then push a pair across the wrap.
        do_reset();
        push1(64'h20);
        for (int i = 0; i < DEPTH - 2; i++) step(0, 0, 1, 0, 1, 0, 64'h21 + 64'(i), 64'h0);
        step(0, 0, 0, 0, 1, 0, 64'h0, 64'h0);
        push2(64'hD0, 64'hD1);
        chk("wrap head0", qif.out_data0, 64'hD0);
        chk("wrap head1", qif.out_data1, 64'hD1);
        step(0, 0, 0, 0, 1, 1, 64'h0, 64'h0);
        chk("wrap drained", 64'(qif.fifo_empty), 64'd1);

        // Flush wins over same-cycle push and pop.
        push2(64'h30, 64'h31);
        push2(64'h32, 64'h33);
        push1(64'h34);
        step(0, 1, 1, 1, 1, 1, 64'h35, 64'h36);
        chk("flush count", 64'(qif.count), 64'd0);
        push1(64'hE0);
        chk("post flush head0", qif.out_data0, 64'hE0);

`ifdef INST_QUEUE_ERR_CHK_EN
        do_reset();
        chk("err after reset", 64'(qif.err_sticky), 64'd0);
        push2(64'h40, 64'h41);
        push1(64'h42);
        step(0, 0, 0, 0, 0, 1, 64'h0, 64'h0);
        chk("lone slave count", 64'(qif.count), 64'd3);
        chk("lone slave err", 64'(qif.err_sticky), 64'd1);
        idle();
        idle();
        chk("err holds", 64'(qif.err_sticky), 64'd1);
        do_reset();
        chk("err cleared", 64'(qif.err_sticky), 64'd0);
`endif

        // Randomized traffic including illegal requests, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            bit r  = ($urandom_range(0, 199) == 0);
            bit f  = ($urandom_range(0, 39) == 0);
            bit p0 = ($urandom_range(0, 9) < 6);
            bit p1 = ($urandom_range(0, 9) < 5);
            bit pm = ($urandom_range(0, 9) < 5);
            bit ps = ($urandom_range(0, 9) < 5);
            logic [63:0] a = {$urandom, $urandom};
            logic [63:0] b = {$urandom, $urandom};
            step(r, f, p0, p1, pm, ps, a, b);
        end

        idle();
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
